// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo: buffers signed audio samples and hands them to the SPI DAC driver as
// rounded, saturated 12-bit offset binary, one sample per frame strobe. The FIFO stores
// the already-converted 12-bit value, so the pop path is a plain register load.
module dac_sample_fifo #(
  parameter int unsigned IN_W       = 16,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  dac_ena,
  output logic [11:0]           dac_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt,
  input  logic                  clear_cnt
);

  localparam int unsigned          Depth     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  LevelFull = (DEPTH_LOG2 + 1)'(Depth);
  // Half an output LSB, for round-half-up before truncating to 12 bits.
  localparam logic [IN_W:0]        RoundInc  = (IN_W + 1)'(1) << (IN_W - 13);
  localparam logic [11:0]          Midscale  = 12'h800;

  logic [11:0]           mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [11:0]           dac_data_q, dac_data_d;
  logic                  underrun_q, underrun_d;
  logic [15:0]           cnt_q, cnt_d;

  logic                  push;
  logic                  pop;
  logic                  starve;

  logic [IN_W:0]         sum_ext;
  logic [12:0]           shifted;
  logic [11:0]           sat;
  logic [11:0]           conv_data;
  logic                  unused_round_bits;

  // Sample conversion: sign-extend, add half LSB, keep the top 13 bits, clamp to 12.
  always_comb begin
    sum_ext = {in_data[IN_W-1], in_data} + RoundInc;
    // Taking the top 13 bits is the arithmetic shift right by IN_W-12.
    shifted = sum_ext[IN_W -: 13];
    if (shifted[12] != shifted[11]) begin
      sat = shifted[12] ? 12'h800 : 12'h7FF;
    end else begin
      sat = shifted[11:0];
    end
    // Two's complement to offset binary.
    conv_data = {~sat[11], sat[10:0]};
  end

  // Fraction bits below the output LSB only matter through the rounding carry.
  assign unused_round_bits = ^sum_ext[IN_W-13:0];

  assign in_ready = (level_q != LevelFull);
  assign push     = in_valid && in_ready;
  assign pop      = dac_ena && (level_q != '0);
  assign starve   = dac_ena && (level_q == '0);

  // Next-state for pointers, occupancy, output sample and underrun bookkeeping.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    dac_data_d = dac_data_q;
    underrun_d = starve;
    cnt_d      = cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end

    // An empty FIFO never pops, even with a same-cycle push: no fall-through.
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(1);
      dac_data_d = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
      default: level_d = level_q;
    endcase

    // Clear beats a coincident underrun; the pulse itself is unaffected.
    if (clear_cnt) begin
      cnt_d = '0;
    end else if (starve && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Control state; reset discards the FIFO by zeroing pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      dac_data_q <= Midscale;
      underrun_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      dac_data_q <= dac_data_d;
      underrun_q <= underrun_d;
      cnt_q      <= cnt_d;
    end
  end

  // Sample storage; no reset needed since stale entries are unreachable after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= conv_data;
    end
  end

  assign dac_data     = dac_data_q;
  assign level        = level_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_dac_sample_fifo.sv
// Bench for dac_sample_fifo: directed scenarios plus randomized traffic, checked against a
// queue-based reference model that applies the conversion rules with integer arithmetic.
module tb_dac_sample_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        dac_ena = 1'b0;
  logic [11:0] dac_data;
  logic [4:0]  level;
  logic        underrun;
  logic [15:0] underrun_cnt;
  logic        clear_cnt = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [11:0] m_q[$];
  logic [11:0] m_dac   = 12'h800;
  logic        m_under = 1'b0;
  int          m_cnt   = 0;

  dac_sample_fifo #(
    .IN_W       (16),
    .DEPTH_LOG2 (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dac_ena      (dac_ena),
    .dac_data     (dac_data),
    .level        (level),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .clear_cnt    (clear_cnt)
  );

  always #5 clk = ~clk;

  // Round half up, floor-shift by 4, clamp to 12-bit signed, then offset by midscale.
  function automatic logic [11:0] conv(input logic [15:0] d);
    int s;
    int t;
    s = $signed(d);
    s = s + 8;
    t = s >>> 4;
    if (t > 2047) t = 2047;
    if (t < -2048) t = -2048;
    return 12'(t + 2048);
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_dac   = 12'h800;
    m_under = 1'b0;
    m_cnt   = 0;
  endfunction

  // One clock with the given inputs; called at posedge+1, returns at posedge+1.
  task automatic step(input logic v, input logic [15:0] d, input logic e, input logic c);
    int   pre;
    logic acc;
    in_valid  = v;
    in_data   = d;
    dac_ena   = e;
    clear_cnt = c;
    pre = m_q.size();
    acc = v && (pre != DEPTH);
    @(posedge clk);
    #1;
    m_under = 1'b0;
    if (e) begin
      if (pre > 0) begin
        m_dac = m_q.pop_front();
      end else begin
        m_under = 1'b1;
        if (m_cnt != 65535) m_cnt++;
      end
    end
    if (c) m_cnt = 0;
    if (acc) m_q.push_back(conv(d));
    in_valid  = 1'b0;
    dac_ena   = 1'b0;
    clear_cnt = 1'b0;
  endtask

  task automatic drain();
    while (m_q.size() > 0) step(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (dac_data !== 12'h800) $display("FAIL reset_dac_data: got %h want 800", dac_data);
    else n_pass++;
    n_checks++;
    if (level !== 5'd0) $display("FAIL reset_level: got %0d want 0", level);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    n_checks++;
    if (underrun_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", underrun_cnt);
    else n_pass++;
    n_checks++;
    if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun);
    else n_pass++;
  endtask

  task automatic test_conversion();
    logic [15:0] vin  [6] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0008, 16'hFFF8, 16'h1234};
    logic [11:0] vout [6] = '{12'hFFF, 12'h000, 12'h800, 12'h801, 12'h800, 12'h923};
    for (int i = 0; i < 6; i++) step(1'b1, vin[i], 1'b0, 1'b0);
    n_checks++;
    if (level !== 5'd6) $display("FAIL conv_level: got %0d want 6", level);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (dac_data !== vout[i]) $display("FAIL conv_%0d: got %h want %h", i, dac_data, vout[i]);
      else n_pass++;
    end
    // A handful of random samples through the model's conversion.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      step(1'b1, r, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (dac_data !== conv(r)) $display("FAIL conv_rand: in %h got %h want %h", r, dac_data,
                                         conv(r));
      else n_pass++;
    end
  endtask

  task automatic test_fill_wrap();
    int k;
    k = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 16'(k * 256), 1'b0, 1'b0);
      k++;
    end
    n_checks++;
    if (level !== 5'd16) $display("FAIL full_level: got %0d want 16", level);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", in_ready);
    else n_pass++;
    // Push attempt while full is refused; the pop frees one slot.
    step(1'b1, 16'hDEAD, 1'b1, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL full_pop_ready: got %b want 1", in_ready);
    else n_pass++;
    n_checks++;
    if (level !== 5'd15) $display("FAIL full_pop_level: got %0d want 15", level);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 16'(k * 256), 1'b1, 1'b0);
      k++;
      n_checks++;
      if (dac_data !== m_dac) $display("FAIL wrap_pop_%0d: got %h want %h", i, dac_data, m_dac);
      else n_pass++;
    end
    while (m_q.size() > 0) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (dac_data !== m_dac) $display("FAIL wrap_drain: got %h want %h", dac_data, m_dac);
      else n_pass++;
    end
  endtask

  task automatic test_underrun();
    logic [11:0] last;
    drain();
    step(1'b0, 16'h0, 1'b0, 1'b1);
    last = m_dac;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (underrun !== 1'b1) $display("FAIL ur_pulse_%0d: got %b want 1", i, underrun);
      else n_pass++;
      step(1'b0, 16'h0, 1'b0, 1'b0);
      n_checks++;
      if (underrun !== 1'b0) $display("FAIL ur_pulse_end_%0d: got %b want 0", i, underrun);
      else n_pass++;
    end
    n_checks++;
    if (dac_data !== last) $display("FAIL ur_hold: got %h want %h", dac_data, last);
    else n_pass++;
    n_checks++;
    if (underrun_cnt !== 16'd3) $display("FAIL ur_cnt: got %0d want 3", underrun_cnt);
    else n_pass++;
    step(1'b0, 16'h0, 1'b1, 1'b1);
    n_checks++;
    if (underrun !== 1'b1) $display("FAIL ur_clear_pulse: got %b want 1", underrun);
    else n_pass++;
    n_checks++;
    if (underrun_cnt !== 16'd0) $display("FAIL ur_clear_cnt: got %0d want 0", underrun_cnt);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [15:0] d;
    drain();
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    step(1'b1, 16'h4321, 1'b1, 1'b0);
    n_checks++;
    if (level !== 5'd5) $display("FAIL sim_level5: got %0d want 5", level);
    else n_pass++;
    n_checks++;
    if (dac_data !== m_dac) $display("FAIL sim_pop5: got %h want %h", dac_data, m_dac);
    else n_pass++;
    drain();
    d = 16'($urandom);
    step(1'b1, d, 1'b1, 1'b0);
    n_checks++;
    if (underrun !== 1'b1) $display("FAIL sim_empty_ur: got %b want 1", underrun);
    else n_pass++;
    n_checks++;
    if (level !== 5'd1) $display("FAIL sim_empty_level: got %0d want 1", level);
    else n_pass++;
    step(1'b0, 16'h0, 1'b1, 1'b0);
    n_checks++;
    if (dac_data !== conv(d)) $display("FAIL sim_empty_pop: got %h want %h", dac_data, conv(d));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    drain();
    for (int i = 0; i < 9; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    n_checks++;
    if (level !== 5'd9) $display("FAIL mid_pre_level: got %0d want 9", level);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (level !== 5'd0) $display("FAIL mid_level: got %0d want 0", level);
    else n_pass++;
    n_checks++;
    if (dac_data !== 12'h800) $display("FAIL mid_dac: got %h want 800", dac_data);
    else n_pass++;
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 16'h0, 1'b1, 1'b0);
    n_checks++;
    if (underrun !== 1'b1) $display("FAIL mid_after_ur: got %b want 1", underrun);
    else n_pass++;
    n_checks++;
    if (underrun_cnt !== 16'd1) $display("FAIL mid_after_cnt: got %0d want 1", underrun_cnt);
    else n_pass++;
  endtask

  // Randomized traffic, every output compared with the model after every clock.
  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), 16'($urandom), ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 29) == 0));
      n_checks++;
      if (dac_data !== m_dac || level !== 5'(m_q.size()) || underrun !== m_under ||
          underrun_cnt !== 16'(m_cnt) || in_ready !== (m_q.size() != DEPTH)) begin
        if (errs < 10) $display("FAIL rand_%0d: dac %h/%h lvl %0d/%0d ur %b/%b cnt %0d/%0d", i,
                                dac_data, m_dac, level, m_q.size(), underrun, m_under,
                                underrun_cnt, m_cnt);
        errs++;
      end else begin
        n_pass++;
      end
    end
  endtask

  // Frame strobes every 50 clocks against a faster ramp producer.
  task automatic test_integration();
    int pushed;
    int popped;
    logic [15:0] ramp;
    drain();
    pushed = 0;
    popped = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'(pushed * 97 - 3000), 1'b0, 1'b0);
      pushed++;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic v;
      logic e;
      logic acc;
      v    = (cyc % 23 == 0);
      e    = (cyc % 50 == 49);
      ramp = 16'(pushed * 97 - 3000);
      acc  = v && (m_q.size() != DEPTH);
      step(v, ramp, e, 1'b0);
      if (acc) pushed++;
      if (e) begin
        n_checks++;
        if (dac_data !== conv(16'(popped * 97 - 3000)) || underrun !== 1'b0)
          $display("FAIL frame_%0d: got %h ur %b want %h", popped, dac_data, underrun,
                   conv(16'(popped * 97 - 3000)));
        else n_pass++;
        popped++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_fill_wrap();
    test_underrun();
    test_simultaneous();
    test_reset_mid();
    test_random();
    test_integration();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dac_sample_fifo.md
# dac_sample_fifo

Sample buffer and format converter between the synthesis datapath and `spi_dac_out`. Accepts signed two's-complement audio samples over a valid/ready handshake and buffers them in a small FIFO. On each frame strobe from the SPI DAC driver (`ena_out` → `dac_ena`), it pops one sample and presents it on `dac_data` as rounded, saturated 12-bit offset binary. Underruns hold the last sample and are counted.

## Interface
- `IN_W`, 16: input sample width, signed; must be ≥ 13.
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries (default 16).
- `clk`  in  1  system clock; same clock as `spi_dac_out`.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  IN_W  signed sample from the synth datapath.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a sample (not full).
- `dac_ena`  in  1  one-cycle pop strobe; connects to `spi_dac_out.ena_out`.
- `dac_data`  out  12  offset-binary sample; connects to `spi_dac_out.data_in`.
- `level`  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2.
- `underrun`  out  1  one-cycle pulse on each pop attempt while empty.
- `underrun_cnt`  out  16  saturating underrun counter.
- `clear_cnt`  in  1  synchronous clear of `underrun_cnt`.

## Operation
- **Reset (asynchronous, takes effect immediately):**
  - Read/write pointers and `level` = 0.
  - `dac_data` = 12'h800 (midscale silence).
  - `underrun` = 0, `underrun_cnt` = 0.
  - `in_ready` = 1 once reset is released (FIFO empty).
  - Reset mid-operation discards all FIFO contents.
- **Push:**
  - Occurs when `in_valid && in_ready`.
  - The converted 12-bit value is written at the write pointer; the pointer wraps modulo 2^DEPTH_LOG2.
  - `in_ready` = (`level` != 2^DEPTH_LOG2), derived combinationally from the registered `level`.
- **Conversion (applied at push; the FIFO stores 12 bits):**
  - s = `in_data` + 2^(IN_W-13), computed at IN_W+1 bits signed (round half up).
  - t = s >>> (IN_W-12), arithmetic shift.
  - Saturate t to [-2048, 2047].
  - `dac_data` value = t with bit 11 inverted.
- **Pop:**
  - `dac_ena` with `level` > 0: read the entry at the read pointer into the `dac_data` register; advance the read pointer with wrap.
  - `dac_ena` with `level` = 0: `dac_data` holds its previous value; `underrun` pulses; `underrun_cnt` increments, saturating at 16'hFFFF.
- **Simultaneous push and pop:**
  - Non-empty: both take effect; `level` is unchanged.
  - Empty: the pop is an underrun, and the pushed sample is stored. There is no fall-through.
  - Full: `in_ready` = 0, so no push occurs. The pop frees a slot and `in_ready` rises the next cycle.
- **Counter clear:** `clear_cnt` zeroes `underrun_cnt` next cycle. If an underrun happens in the same cycle, clear wins and the counter reads 0. The `underrun` pulse is still produced.
- `dac_ena` may be asserted on any cycle, including back-to-back. No minimum spacing is assumed.

## Timing
- Push in cycle N:
  - `level` increments at N+1.
  - The sample is poppable by a `dac_ena` in cycle N+1 or later.
- `dac_ena` in cycle N:
  - `dac_data` updates at N+1 and is otherwise stable.
  - `underrun` is high during N+1 only.
  - `underrun_cnt` updates at N+1.
- `level` and `in_ready` reflect state after the edge; full-to-not-full and not-full-to-full transitions are seen one cycle after the causing event.
- All outputs are registered except `in_ready` (registered `level` through a single compare).
- With the default SPI driver, frames occur every 50 `clk` cycles. Upstream must sustain one sample per 50 cycles on average.

## Test plan
- **Reset values:** release reset with no stimulus. Expect:
  - `dac_data` = 12'h800, `level` = 0, `in_ready` = 1, `underrun_cnt` = 0.
- **Conversion:** push 16'h7FFF, 16'h8000, 16'h0000, 16'h0008, 16'hFFF8, 16'h1234, then pop six times. Expect `dac_data` sequence 12'hFFF, 12'h000, 12'h800, 12'h801, 12'h800, 12'h923.
- **Fill, full and wrap:** hold `in_valid` = 1 with an incrementing ramp and no pops.
  - Expect `level` = 16 and `in_ready` = 0 after 16 accepted pushes.
  - Then one `dac_ena`: `in_ready` = 1 the following cycle.
  - Continue 40 push/pop pairs across pointer wrap: popped values match pushed order exactly.
- **Underrun:** on an empty FIFO, issue three `dac_ena` strobes. Expect:
  - `dac_data` stays at its last value; three one-cycle `underrun` pulses; `underrun_cnt` = 3.
  - Then `clear_cnt` together with a fourth strobe: count = 0 and a pulse is still seen.
- **Simultaneous events:**
  - Push and `dac_ena` in the same cycle with `level` = 5: `level` stays 5.
  - Same with `level` = 0: `underrun` pulses, `level` becomes 1, and the next `dac_ena` returns that sample.
- **Reset mid-operation:** assert `reset` asynchronously (between clock edges) with `level` = 9. Expect:
  - `level` = 0 and `dac_data` = 12'h800 immediately.
  - After release, the first `dac_ena` gives an underrun.
- **Integration:** connect to `spi_dac_out` and push a ramp. Expect each SPI frame's 12 data bits to equal successive FIFO entries, with no skipped or repeated samples while `level` > 0.
